// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern controller.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } bist_state_e;

  // x^16+x^14+x^13+x^11+1 expressed as a mask over bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'h0001;

endpackage

// File: rtl/bist_pattern_ctrl_if.sv
// Request/response bundle between a BIST requester/target and the pattern controller.
interface bist_pattern_ctrl_if #(
  parameter int unsigned PI_W  = 3,
  parameter int unsigned PO_W  = 2,
  parameter int unsigned CNT_W = 16
);

  logic             start;
  logic             abort;
  logic [15:0]      seed;
  logic [CNT_W-1:0] n_patterns;
  logic [PO_W-1:0]  po_in;
  logic [PI_W-1:0]  pi_out;
  logic             busy;
  logic             done;
  logic [15:0]      signature;

  modport master (
    output start, abort, seed, n_patterns, po_in,
    input  pi_out, busy, done, signature
  );

  modport slave (
    input  start, abort, seed, n_patterns, po_in,
    output pi_out, busy, done, signature
  );

endinterface

// File: rtl/lfsr16_step.sv
// One Fibonacci shift of a 16-bit register; feedback is the parity of the tapped bits.
module lfsr16_step (
  input  logic [15:0] state_i,
  input  logic [15:0] taps_i,
  output logic [15:0] next_c_o
);

  assign next_c_o = {state_i[14:0], ^(state_i & taps_i)};

endmodule

// File: rtl/bist_pattern_ctrl.sv
// BIST controller: LFSR patterns onto the target inputs, responses folded into a signature.
// Define BIST_MISR_EN for MISR compaction; otherwise signature holds the last captured po_in.
module bist_pattern_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned PI_W   = 3,
  parameter int unsigned PO_W   = 2,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SETTLE = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  bist_pattern_ctrl_if.slave  bus
);

  localparam int unsigned SET_W = $clog2(SETTLE + 1);

  bist_state_e      state_q;
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_d;
  logic [15:0]      sig_q;
  logic [15:0]      sig_d;
  logic [CNT_W-1:0] cnt_q;
  logic [SET_W-1:0] settle_q;
  logic [PI_W-1:0]  pi_out_q;
  logic             busy_q;
  logic             done_q;
  logic [15:0]      seed_eff;

  // An all-zero seed would lock the LFSR, so it is replaced by the default.
  assign seed_eff = (bus.seed == 16'h0000) ? DEFAULT_SEED : bus.seed;

  lfsr16_step u_lfsr_step (
    .state_i  (lfsr_q),
    .taps_i   (LFSR_TAPS),
    .next_c_o (lfsr_d)
  );

`ifdef BIST_MISR_EN
  logic [15:0] misr_shift;

  lfsr16_step u_misr_step (
    .state_i  (sig_q),
    .taps_i   (LFSR_TAPS),
    .next_c_o (misr_shift)
  );

  assign sig_d = misr_shift ^ 16'(bus.po_in);
`else
  assign sig_d = 16'(bus.po_in);
`endif

  // Run sequencing; done is registered from the DONE state so it trails it by a cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= DEFAULT_SEED;
      sig_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      pi_out_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != ST_IDLE) && bus.abort) begin
        state_q  <= ST_IDLE;
        settle_q <= '0;
        pi_out_q <= '0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.start) begin
              lfsr_q   <= seed_eff;
              sig_q    <= '0;
              cnt_q    <= bus.n_patterns;
              settle_q <= '0;
              if (bus.n_patterns == '0) begin
                state_q <= ST_DONE;
              end else begin
                state_q  <= ST_APPLY;
                busy_q   <= 1'b1;
                pi_out_q <= seed_eff[PI_W-1:0];
              end
            end
          end
          ST_APPLY: begin
            settle_q <= settle_q + SET_W'(1);
            if (settle_q == SET_W'(SETTLE - 1)) begin
              state_q <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            sig_q    <= sig_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_q - CNT_W'(1);
            settle_q <= '0;
            if (cnt_q == CNT_W'(1)) begin
              state_q  <= ST_DONE;
              busy_q   <= 1'b0;
              pi_out_q <= '0;
            end else begin
              state_q  <= ST_APPLY;
              pi_out_q <= lfsr_d[PI_W-1:0];
            end
          end
          ST_DONE: begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.pi_out    = pi_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.signature = sig_q;

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Self-checking bench for bist_pattern_ctrl: directed vector table, corner sequences, random runs.
module tb_bist_pattern_ctrl;

  localparam int unsigned PI_W   = 3;
  localparam int unsigned PO_W   = 2;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SETTLE = 1;

  logic sys_clk;
  logic sys_rst;

  int n_checks = 0;
  int n_fail   = 0;

  bist_pattern_ctrl_if #(.PI_W(PI_W), .PO_W(PO_W), .CNT_W(CNT_W)) bif ();

  bist_pattern_ctrl #(
    .PI_W   (PI_W),
    .PO_W   (PO_W),
    .CNT_W  (CNT_W),
    .SETTLE (SETTLE)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bif)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 500000)", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, got, exp, $time);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1 as plain shifts and parity.
  function automatic logic [15:0] poly_step(input logic [15:0] r);
    logic [15:0] fb;
    fb = ((r >> 15) ^ (r >> 13) ^ (r >> 12) ^ (r >> 10)) & 16'd1;
    return 16'((r << 1) | fb);
  endfunction

  function automatic logic [15:0] fold(input logic [15:0] acc, input logic [PO_W-1:0] po);
`ifdef BIST_MISR_EN
    return poly_step(acc) ^ 16'(po);
`else
    return 16'(po) | (acc & 16'h0000);
`endif
  endfunction

  // One complete run, checked cycle by cycle against the pattern/timing rules.
  task automatic run_check(input logic [15:0] s, input int n, input bit rand_po,
                           input logic [PO_W-1:0] po_fix, input bit hold_start,
                           output logic [15:0] sig_got);
    logic [15:0] r;
    logic [15:0] exp_sig;
    int per;
    int total;
    per     = SETTLE + 1;
    total   = n * per + 1;
    r       = (s == 16'h0000) ? 16'h0001 : s;
    exp_sig = 16'h0000;
    sig_got = 16'h0000;
    bif.seed       = s;
    bif.n_patterns = CNT_W'(n);
    bif.po_in      = rand_po ? PO_W'($urandom) : po_fix;
    bif.start      = 1'b1;
    for (int c = 0; c <= total; c++) begin
      @(negedge sys_clk);
      if (!hold_start) bif.start = 1'b0;
      if (c < n * per) begin
        check("run_busy", 32'(bif.busy), 32'd1);
        check("run_pi_out", 32'(bif.pi_out), 32'(PI_W'(r)));
        check("run_done_early", 32'(bif.done), 32'd0);
      end else if (c == n * per) begin
        check("end_busy", 32'(bif.busy), 32'd0);
        check("end_pi_out", 32'(bif.pi_out), 32'd0);
        check("end_done_early", 32'(bif.done), 32'd0);
      end else begin
        check("done_pulse", 32'(bif.done), 32'd1);
        check("done_busy", 32'(bif.busy), 32'd0);
        check("done_signature", 32'(bif.signature), 32'(exp_sig));
        sig_got = bif.signature;
      end
      if (c < total) begin
        bif.po_in = rand_po ? PO_W'($urandom) : po_fix;
        if (((c + 1) % per == 0) && (c + 1 <= n * per)) begin
          exp_sig = fold(exp_sig, bif.po_in);
          r       = poly_step(r);
        end
      end
    end
  endtask

  typedef struct {
    logic [15:0]     seed;
    int              n;
    logic [PO_W-1:0] po;
    logic [15:0]     exp_sig;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] sig_a;
    logic [15:0] sig_b;
    bit          seen_done;

`ifdef BIST_MISR_EN
    vecs[0] = '{seed: 16'h0001, n: 4, po: 2'b00, exp_sig: 16'h0000};
    vecs[1] = '{seed: 16'h0001, n: 3, po: 2'b01, exp_sig: 16'h0007};
    vecs[2] = '{seed: 16'h0001, n: 3, po: 2'b00, exp_sig: 16'h0000};
    vecs[3] = '{seed: 16'h0000, n: 2, po: 2'b10, exp_sig: 16'h0006};
    vecs[4] = '{seed: 16'h1234, n: 0, po: 2'b11, exp_sig: 16'h0000};
    vecs[5] = '{seed: 16'h0001, n: 4, po: 2'b11, exp_sig: 16'h0011};
`else
    vecs[0] = '{seed: 16'h0001, n: 4, po: 2'b00, exp_sig: 16'h0000};
    vecs[1] = '{seed: 16'h0001, n: 3, po: 2'b01, exp_sig: 16'h0001};
    vecs[2] = '{seed: 16'h0001, n: 3, po: 2'b00, exp_sig: 16'h0000};
    vecs[3] = '{seed: 16'h0000, n: 2, po: 2'b10, exp_sig: 16'h0002};
    vecs[4] = '{seed: 16'h1234, n: 0, po: 2'b11, exp_sig: 16'h0000};
    vecs[5] = '{seed: 16'h0001, n: 4, po: 2'b11, exp_sig: 16'h0003};
`endif

    sys_rst        = 1'b1;
    bif.start      = 1'b0;
    bif.abort      = 1'b0;
    bif.seed       = 16'h0000;
    bif.n_patterns = '0;
    bif.po_in      = '0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    check("rst_pi_out", 32'(bif.pi_out), 32'd0);
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_done", 32'(bif.done), 32'd0);
    check("rst_signature", 32'(bif.signature), 32'd0);

    // Directed table: hand-computed signatures.
    for (int i = 0; i < 6; i++) begin
      run_check(vecs[i].seed, vecs[i].n, 1'b0, vecs[i].po, 1'b0, sig_a);
      check($sformatf("table_sig[%0d]", i), 32'(sig_a), 32'(vecs[i].exp_sig));
    end

    // Signature is held after done.
    repeat (4) @(negedge sys_clk);
    check("sig_held", 32'(bif.signature), 32'(vecs[5].exp_sig));

    // Abort during the second APPLY.
    bif.seed = 16'h0001; bif.n_patterns = CNT_W'(4); bif.po_in = 2'b01; bif.start = 1'b1;
    @(negedge sys_clk); bif.start = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("abort_pre_pi", 32'(bif.pi_out), 32'd2);
    bif.abort = 1'b1;
    @(negedge sys_clk);
    bif.abort = 1'b0;
    check("abort_busy", 32'(bif.busy), 32'd0);
    check("abort_pi_out", 32'(bif.pi_out), 32'd0);
    check("abort_partial_sig", 32'(bif.signature), 32'd1);
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge sys_clk);
      seen_done = seen_done | bif.done;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    run_check(16'h00A5, 3, 1'b1, 2'b00, 1'b0, sig_a);

    // Start held high through a run, then a back-to-back identical run.
    run_check(16'hACE1, 3, 1'b0, 2'b11, 1'b1, sig_a);
    run_check(16'hACE1, 3, 1'b0, 2'b11, 1'b0, sig_b);
    check("b2b_same_sig", 32'(sig_b), 32'(sig_a));

    // Reset pulse during CAPTURE.
    bif.seed = 16'h1234; bif.n_patterns = CNT_W'(5); bif.po_in = 2'b11; bif.start = 1'b1;
    @(negedge sys_clk); bif.start = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("midrst_pi_out", 32'(bif.pi_out), 32'd0);
    check("midrst_busy", 32'(bif.busy), 32'd0);
    check("midrst_done", 32'(bif.done), 32'd0);
    check("midrst_signature", 32'(bif.signature), 32'd0);
    run_check(16'h0001, 3, 1'b0, 2'b01, 1'b0, sig_a);
    check("post_rst_sig", 32'(sig_a), 32'(vecs[1].exp_sig));

    // Randomized runs against the reference rules.
    for (int t = 0; t < 20; t++) begin
      logic [15:0] s;
      s = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      run_check(s, int'($urandom_range(0, 6)), 1'b1, 2'b00, 1'(t % 3 == 0), sig_a);
    end
    bif.start = 1'b0;
    repeat (3) @(negedge sys_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
